fp_cvt_sched: RTL
=================

# fp_cvt_sched

Round-robin scheduler that shares one int32-to-double conversion datapath (fcvt.d.w) between NREQ issue ports. Accepts operands over per-port valid/ready handshakes, registers the winning operand, converts it in a registered stage, and returns a tagged 64-bit IEEE 754 result over a single valid/ready response port. Sits between the D-extension issue logic and the FP writeback arbiter.

## Interface
- NREQ, 2: number of requesters, 2..8
- TAG_W, 4: width of the opaque tag carried with each request
- SRC_W, $clog2(NREQ): width of the source index (derived, not overridable)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  NREQ  per-port request valid
- req_ready  out  NREQ  per-port accept; at most one bit high per cycle
- req_data  in  NREQ*32  per-port signed int32 operand, port i at [32*i+31:32*i]
- req_tag  in  NREQ*TAG_W  per-port tag
- flush  in  1  synchronous kill of all in-flight work
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accept
- rsp_data  out  64  double result {sign, exp[10:0], frac[51:0]}
- rsp_tag  out  TAG_W  tag of the request that produced rsp_data
- rsp_src  out  SRC_W  index of the originating port
- busy  out  1  v1 | v2

## Operation
- Two pipeline registers: S1 (operand, tag, src, v1) and S2 (result, tag, src, v2). S2 drives rsp_* directly.
- adv2 = !v2 | rsp_ready; adv1 = !v1 | adv2 (S1 empties when it can move to S2).
- Arbitration: when adv1, grant the first i with req_valid[i] set, scanning from rr_ptr upward with wrap. req_ready[i] = adv1 & grant[i]; nothing granted when adv1 = 0.
- rr_ptr updates only on a handshake: rr_ptr <= (winner+1) mod NREQ. rr_ptr is not changed by flush.
- Conversion (S1->S2), exact, no rounding or flags: zero -> 64'h0; else sign = w[31], mag = |w| (0x80000000 -> 2^31), exp = 1023 + msb_index(mag), frac = mag with implicit 1 removed, left-justified into 52 bits.
- flush: v1 <= 0, v2 <= 0 next edge; req_ready forced 0 that cycle (no accept). rsp_valid may be high in the flush cycle; a handshake there counts as delivered.
- Holding: while v2 & !rsp_ready, rsp_data/tag/src stay stable.

## Timing
- Reset values: v1 = v2 = 0, rr_ptr = 0, rsp_valid = 0, rsp_data = 0, rsp_tag = 0, rsp_src = 0, busy = 0, req_ready = 0.
- Latency: request handshake at edge N -> rsp_valid high after edge N+1 (2 cycles from request presentation to response visible).
- Throughput: 1 result/cycle with rsp_ready held high.
- Backpressure: rsp_ready low with S1 and S2 full -> req_ready all 0; no data lost or duplicated.
- Simultaneous: S2 drains and S1 refills in the same cycle is legal; S1->S2 move and new S1 capture in one edge.
- Reset asserted mid-operation: all outputs return to reset values immediately (async), in-flight work discarded.

## Structure
- Shared package fp_d_pkg: DBL_BIAS = 11'd1023, DBL_EXP_W = 11, DBL_FRAC_W = 52, the double-result struct/width constant.
- One sub-module: fp_cvt_rr_arb (NREQ-wide round-robin priority picker: req, ptr -> one-hot grant, winner index, any). Conversion logic lives in the S1->S2 stage of this block.

## Test plan
- Single port 0, data 32'h00000001, tag 3, rsp_ready=1 -> rsp_data 64'h3FF0000000000000, tag 3, src 0, rsp_valid 2 cycles after req presented.
- Values -1, 5, 0, 32'h80000000 back-to-back on port 1 -> 64'hBFF0000000000000, 64'h4014000000000000, 64'h0, 64'hC1E0000000000000 on consecutive cycles, order preserved.
- NREQ=2, both ports valid continuously -> grants alternate 0,1,0,1 starting with 0 after reset; rsp_src alternates accordingly.
- rsp_ready low 5 cycles with both ports valid -> exactly 2 accepts then all req_ready 0; rsp_data stable; on release, results drain in order with no loss.
- flush with v1=v2=1 -> next cycle rsp_valid=0, busy=0; no req_ready in flush cycle; rr_ptr unchanged.
- rst_n pulsed low mid-stream for less than one clock period -> all outputs at reset values asynchronously, first grant afterwards goes to port 0.

Source files
------------

// File: rtl/fp_d_pkg.sv
// rtl/fp_d_pkg.sv - IEEE 754 double-precision constants and result layout
package fp_d_pkg;

  localparam int DBL_W = 64;
  localparam int DBL_EXP_W = 11;
  localparam int DBL_FRAC_W = 52;
  localparam logic [DBL_EXP_W-1:0] DBL_BIAS = 11'd1023;

  typedef struct packed {
    logic                  sign;
    logic [DBL_EXP_W-1:0]  exp;
    logic [DBL_FRAC_W-1:0] frac;
  } dbl_t;

endpackage

// File: rtl/fp_cvt_sched_if.sv
// rtl/fp_cvt_sched_if.sv - request ports and tagged response port of the conversion scheduler
interface fp_cvt_sched_if #(
  parameter int NREQ  = 2,
  parameter int TAG_W = 4
);
  localparam int SRC_W = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*32-1:0]    req_data;
  logic [NREQ*TAG_W-1:0] req_tag;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [63:0]           rsp_data;
  logic [TAG_W-1:0]      rsp_tag;
  logic [SRC_W-1:0]      rsp_src;

  modport master (
    output req_valid, req_data, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_tag, rsp_src
  );

  modport slave (
    input  req_valid, req_data, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_tag, rsp_src
  );

endinterface

// File: rtl/fp_cvt_rr_arb.sv
// rtl/fp_cvt_rr_arb.sv - round-robin priority picker, scans from ptr upward with wrap
module fp_cvt_rr_arb #(
  parameter int NREQ  = 2,
  parameter int SRC_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [SRC_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [SRC_W-1:0] idx,
  output logic             any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (int'(ptr) + k) % NREQ;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = SRC_W'(j);
      end
    end
  end

endmodule

// File: rtl/fp_cvt_sched.sv
// rtl/fp_cvt_sched.sv - shares one int32-to-double converter between NREQ ports, two-stage pipeline
module fp_cvt_sched
  import fp_d_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int TAG_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  output logic           busy,
  fp_cvt_sched_if.slave  bus
);

  localparam int SRC_W = $clog2(NREQ);

  logic             v1, v2, adv1, adv2;
  logic [31:0]      s1_data;
  logic [TAG_W-1:0] s1_tag, s2_tag;
  logic [SRC_W-1:0] s1_src, s2_src, rr_ptr;
  dbl_t             s2_res, cvt;

  logic [NREQ-1:0]  arb_req, arb_grant;
  logic [SRC_W-1:0] arb_idx;
  logic             arb_any;

  assign adv2 = !v2 | bus.rsp_ready;
  assign adv1 = !v1 | adv2;

  // Gating with rst_n keeps req_ready low while reset is held
  assign arb_req = bus.req_valid & {NREQ{adv1 & !flush & rst_n}};

  fp_cvt_rr_arb #(.NREQ(NREQ), .SRC_W(SRC_W)) u_arb (
    .req   (arb_req),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  assign bus.req_ready = arb_grant;

  logic [31:0] mag, norm;
  logic [4:0]  msb_idx;

  // |w| of 0x80000000 wraps to itself, which read unsigned is exactly 2^31
  always_comb begin
    mag     = s1_data[31] ? (~s1_data + 32'd1) : s1_data;
    msb_idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (mag[i]) msb_idx = 5'(i);
    end
    norm = mag << (5'd31 - msb_idx);
    cvt  = '0;
    if (mag != 32'd0) begin
      cvt.sign = s1_data[31];
      cvt.exp  = DBL_BIAS + DBL_EXP_W'(msb_idx);
      cvt.frac = {norm[30:0], {(DBL_FRAC_W-31){1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1      <= 1'b0;
      s1_data <= '0;
      s1_tag  <= '0;
      s1_src  <= '0;
      rr_ptr  <= '0;
    end else if (flush) begin
      v1 <= 1'b0;
    end else if (adv1) begin
      v1 <= arb_any;
      if (arb_any) begin
        s1_data <= bus.req_data[32*arb_idx +: 32];
        s1_tag  <= bus.req_tag[TAG_W*arb_idx +: TAG_W];
        s1_src  <= arb_idx;
        rr_ptr  <= (arb_idx == SRC_W'(NREQ-1)) ? '0 : arb_idx + SRC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2     <= 1'b0;
      s2_res <= '0;
      s2_tag <= '0;
      s2_src <= '0;
    end else if (flush) begin
      v2 <= 1'b0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        s2_res <= cvt;
        s2_tag <= s1_tag;
        s2_src <= s1_src;
      end
    end
  end

  assign bus.rsp_valid = v2;
  assign bus.rsp_data  = s2_res;
  assign bus.rsp_tag   = s2_tag;
  assign bus.rsp_src   = s2_src;
  assign busy          = v1 | v2;

endmodule
